// File: rtl/xc_aessub_mc.sv
// ============================================================================
// Module   : xc_aessub_mc
// Purpose  : Multi-cycle xc.aessub execute unit; LANES shared S-box datapaths
//            build the four result bytes, then a one-cycle ready pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module xc_aessub_mc #(
  parameter int LANES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        valid,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        enc,
  input  logic        rot,
  output logic        ready,
  output logic [31:0] result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] C_STEP = 2'(LANES);
  localparam logic [1:0] C_LAST = 2'(4 - LANES);

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 == x^-1 for x != 0, and maps 0 to 0 as the S-box requires
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] fwd_affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] b);
    return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
  endfunction

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       enc_q, enc_d;
  logic       rot_q, rot_d;
  logic [7:0] op_q  [4];
  logic [7:0] op_d  [4];
  logic [7:0] acc_q [4];
  logic [7:0] acc_d [4];
  logic [7:0] w_sb  [LANES];
  logic [31:0] w_word;
  logic        w_unused_bits;

  // Only the selected byte lanes of each source register feed the unit
  assign w_unused_bits = ^{rs1[31:24], rs1[15:8], rs2[23:16], rs2[7:0]};

  // Each lane shares one GF inverter between encrypt and decrypt paths
  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [7:0] w_in;
      logic [7:0] w_pre;
      logic [7:0] w_inv;
      assign w_in    = op_q[cnt_q + 2'(l)];
      assign w_pre   = enc_q ? w_in : inv_affine(w_in);
      assign w_inv   = gf_inv(w_pre);
      assign w_sb[l] = enc_q ? fwd_affine(w_inv) : w_inv;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    enc_d   = enc_q;
    rot_d   = rot_q;
    op_d    = op_q;
    acc_d   = acc_q;
    case (state_q)
      S_IDLE: begin
        if (valid && !flush) begin
          op_d[0] = rs1[7:0];
          op_d[1] = rs2[15:8];
          op_d[2] = rs1[23:16];
          op_d[3] = rs2[31:24];
          enc_d   = enc;
          rot_d   = rot;
          cnt_d   = 2'd0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        for (int l = 0; l < LANES; l++) begin
          acc_d[cnt_q + 2'(l)] = w_sb[l];
        end
        cnt_d = cnt_q + C_STEP;
        if (cnt_q == C_LAST) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      enc_q   <= 1'b0;
      rot_q   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        op_q[i]  <= 8'h00;
        acc_q[i] <= 8'h00;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      enc_q   <= enc_d;
      rot_q   <= rot_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
    end
  end

  assign ready  = (state_q == S_DONE);
  assign w_word = rot_q ? {acc_q[2], acc_q[1], acc_q[0], acc_q[3]}
                        : {acc_q[3], acc_q[2], acc_q[1], acc_q[0]};
  // Gate the accumulator so partial S-box results never reach the bypass bus
  assign result = ready ? w_word : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_xc_aessub_mc.sv
// ============================================================================
// Module   : tb_xc_aessub_mc
// Purpose  : Self-checking bench for xc_aessub_mc with LANES = 1, 2 and 4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xc_aessub_mc;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] rs1 = 32'h0;
  logic [31:0] rs2 = 32'h0;
  logic        enc = 1'b0;
  logic        rot = 1'b0;
  logic [2:0]  rdy;
  logic [31:0] res [3];

  int n_chk  = 0;
  int n_fail = 0;
  int lanes [3] = '{1, 2, 4};

  logic [7:0] sb_fwd [256];
  logic [7:0] sb_inv [256];

  always #5 clock = ~clock;

  xc_aessub_mc #(.LANES(1)) u_l1 (
    .clock(clock), .reset(reset), .flush(flush), .valid(valid),
    .rs1(rs1), .rs2(rs2), .enc(enc), .rot(rot),
    .ready(rdy[0]), .result(res[0]));
  xc_aessub_mc #(.LANES(2)) u_l2 (
    .clock(clock), .reset(reset), .flush(flush), .valid(valid),
    .rs1(rs1), .rs2(rs2), .enc(enc), .rot(rot),
    .ready(rdy[1]), .result(res[1]));
  xc_aessub_mc #(.LANES(4)) u_l4 (
    .clock(clock), .reset(reset), .flush(flush), .valid(valid),
    .rs1(rs1), .rs2(rs2), .enc(enc), .rot(rot),
    .ready(rdy[2]), .result(res[2]));

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
    return 8'((v << k) | (v >> (8 - k)));
  endfunction

  // S-box tables from the generator-3 / inverse walk of GF(2^8)
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ 8'(p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ 8'(q << 1);
      q = q ^ 8'(q << 2);
      q = q ^ 8'(q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sb_fwd[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb_fwd[0] = 8'h63;
    for (int i = 0; i < 256; i++) sb_inv[sb_fwd[i]] = 8'(i);
  endtask

  function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                             input logic e, input logic r);
    logic [7:0]  bi [4];
    logic [31:0] w;
    bi[0] = a[7:0];
    bi[1] = b[15:8];
    bi[2] = a[23:16];
    bi[3] = b[31:24];
    w = 32'h0;
    for (int i = 0; i < 4; i++) w[i*8 +: 8] = e ? sb_fwd[bi[i]] : sb_inv[bi[i]];
    if (r) w = {w[23:0], w[31:24]};
    return w;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Single-cycle valid; operands scrambled while busy to prove they are ignored
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic e,
                        input logic r, input logic [31:0] exp, input string tag);
    int          lat [3];
    int          cnt [3];
    logic [31:0] got [3];
    logic        leak [3];
    for (int d = 0; d < 3; d++) begin
      lat[d] = 0; cnt[d] = 0; got[d] = 32'h0; leak[d] = 1'b0;
    end
    @(negedge clock);
    rs1 = a; rs2 = b; enc = e; rot = r; valid = 1'b1;
    @(posedge clock);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      for (int d = 0; d < 3; d++) begin
        if (rdy[d]) begin
          if (cnt[d] == 0) begin
            lat[d] = k;
            got[d] = res[d];
          end
          cnt[d]++;
        end else if (res[d] != 32'h0) begin
          leak[d] = 1'b1;
        end
      end
      if (k == 1) begin
        valid = 1'b0;
        rs1 = $urandom; rs2 = $urandom; enc = ~e; rot = ~r;
      end
    end
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s L%0d pulses", tag, lanes[d]), 32'(cnt[d]), 32'd1);
      check($sformatf("%s L%0d latency", tag, lanes[d]), 32'(lat[d]), 32'(4 / lanes[d] + 1));
      check($sformatf("%s L%0d result", tag, lanes[d]), got[d], exp);
      check($sformatf("%s L%0d idle_zero", tag, lanes[d]), 32'(leak[d]), 32'd0);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        e;
    logic        r;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int          npulse [3];
    int          k;
    logic [31:0] ra, rb, rexp;
    logic        re, rr;

    tbl[0] = '{32'h00530001, 32'h00000000, 1'b1, 1'b0, 32'h63ED637C};
    tbl[1] = '{32'h00530001, 32'h00000000, 1'b1, 1'b1, 32'hED637C63};
    tbl[2] = '{32'h00ED007C, 32'h63006300, 1'b0, 1'b0, 32'h00530001};
    tbl[3] = '{32'h00ED007C, 32'h63006300, 1'b0, 1'b1, 32'h53000100};
    build_sbox();

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset L%0d ready", lanes[d]), 32'(rdy[d]), 32'd0);
      check($sformatf("reset L%0d result", lanes[d]), res[d], 32'h0);
    end

    for (int i = 0; i < 4; i++)
      run_op(tbl[i].a, tbl[i].b, tbl[i].e, tbl[i].r, tbl[i].exp, $sformatf("vec%0d", i));

    for (int i = 0; i < 16; i++) begin
      ra = $urandom; rb = $urandom; re = 1'($urandom); rr = 1'($urandom);
      rexp = ref_result(ra, rb, re, rr);
      run_op(ra, rb, re, rr, rexp, $sformatf("rnd%0d", i));
    end

    // Flush in the second BUSY cycle
    for (int d = 0; d < 3; d++) npulse[d] = 0;
    @(negedge clock);
    rs1 = tbl[0].a; rs2 = tbl[0].b; enc = 1'b1; rot = 1'b0; valid = 1'b1;
    @(posedge clock);
    for (int n = 1; n <= 7; n++) begin
      @(negedge clock);
      for (int d = 0; d < 3; d++) if (rdy[d]) npulse[d]++;
      if (n == 1) valid = 1'b0;
      if (n == 2) flush = 1'b1;
      if (n == 3) flush = 1'b0;
    end
    check("flush L1 pulses", 32'(npulse[0]), 32'd0);
    check("flush L2 pulses", 32'(npulse[1]), 32'd0);
    check("flush L4 pulses", 32'(npulse[2]), 32'd1);
    check("flush L1 result", res[0], 32'h0);
    run_op(tbl[2].a, tbl[2].b, 1'b0, 1'b0, tbl[2].exp, "postflush");

    // Asynchronous reset between edges while L4 shows ready and L1 is busy
    @(negedge clock);
    rs1 = tbl[0].a; rs2 = tbl[0].b; enc = 1'b1; rot = 1'b1; valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    valid = 1'b0;
    @(posedge clock);
    #3;
    check("areset L4 ready_before", 32'(rdy[2]), 32'd1);
    reset = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("areset L%0d ready", lanes[d]), 32'(rdy[d]), 32'd0);
      check($sformatf("areset L%0d result", lanes[d]), res[d], 32'h0);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int d = 0; d < 3; d++) npulse[d] = 0;
    repeat (6) begin
      @(negedge clock);
      for (int d = 0; d < 3; d++) if (rdy[d]) npulse[d]++;
    end
    for (int d = 0; d < 3; d++)
      check($sformatf("areset L%0d stray_pulse", lanes[d]), 32'(npulse[d]), 32'd0);
    run_op(tbl[1].a, tbl[1].b, 1'b1, 1'b1, tbl[1].exp, "postreset");

    // Back-to-back on LANES=1 with valid held high throughout
    @(negedge clock);
    rs1 = tbl[0].a; rs2 = tbl[0].b; enc = 1'b1; rot = 1'b0; valid = 1'b1;
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (!rdy[0] && k < 12);
    check("b2b first latency", 32'(k), 32'd5);
    check("b2b first result", res[0], tbl[0].exp);
    ra = $urandom; rb = $urandom;
    rexp = ref_result(ra, rb, 1'b0, 1'b1);
    rs1 = ra; rs2 = rb; enc = 1'b0; rot = 1'b1;
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (!rdy[0] && k < 12);
    check("b2b spacing", 32'(k), 32'd6);
    check("b2b second result", res[0], rexp);
    valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
